sint_arb: RTL and testbench

- Shares the single scene-intersection (sint) ray input among three ray sources:
  - reflect rays from send_reflect
  - shadow rays from send_shadow
  - primary rays from the primary ray generator
- Secondary rays take priority to drain in-flight work and avoid deadlock. Primary rays are protected by a starvation counter and throttled by an in-flight credit limit.
- Output is buffered through a 2-entry skid, so the sint stall never propagates combinationally to the sources.

---
 rtl/sint_arb_pkg.sv | 20 ++
 rtl/sint_arb_skid.sv | 59 +++++
 rtl/sint_arb.sv | 135 +++++++++++++
 tb/tb_sint_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sint_arb_pkg.sv
// Shared types and widths for the scene-intersection input arbiter.
package sint_arb_pkg;

  localparam int SINT_ARB_STARVE_W = 4;
  localparam int PRIM_CNT_W        = 7;

  typedef enum logic [1:0] {
    SRC_REFL,
    SRC_SHAD,
    SRC_PRIM
  } arb_src_e;

  // Ray record handed from the shader/generator side to scene intersection.
  typedef struct packed {
    logic        is_shadow;
    logic [15:0] ray_id;
    logic [31:0] payload;
  } shader_to_sint_t;

endpackage

// File: rtl/sint_arb_skid.sv
// Two-entry registered FIFO between the arbiter grant and the sint input.
// The head entry drives the output directly, so sint sees registered data.
module sint_arb_skid
  import sint_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  shader_to_sint_t push_data,
  input  logic            pop,
  output logic [1:0]      occ_q,
  output shader_to_sint_t head
);

  shader_to_sint_t ent0_q;
  shader_to_sint_t ent1_q;
  logic            do_pop;
  logic            do_push;

  // Pops only from a non-empty buffer; pushes only into a free slot.
  always_comb begin
    do_pop  = pop && (occ_q != 2'd0);
    do_push = push && ((occ_q != 2'd2) || do_pop);
  end

  // Occupancy is the only reset state; entry contents are qualified by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
    end else if (do_push && !do_pop) begin
      occ_q <= occ_q + 2'd1;
    end else if (do_pop && !do_push) begin
      occ_q <= occ_q - 2'd1;
    end
  end

  // Entry storage: shift toward the head on pop, fill the first free slot on push.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      if (do_push && (occ_q == 2'd1)) begin
        ent0_q <= push_data;
      end else begin
        ent0_q <= ent1_q;
      end
      if (do_push && (occ_q == 2'd2)) begin
        ent1_q <= push_data;
      end
    end else if (do_push) begin
      if (occ_q == 2'd0) begin
        ent0_q <= push_data;
      end else begin
        ent1_q <= push_data;
      end
    end
  end

  assign head = ent0_q;

endmodule

// File: rtl/sint_arb.sv
// Arbitrates reflect, shadow and primary rays onto the single sint input.
// Secondary rays win by round-robin; primary rays get a starvation escape
// and are throttled by an in-flight credit count. Grants depend only on
// registered state plus the request valids, never on sint_stall.
module sint_arb
  import sint_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int MAX_PRIM   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refl_valid,
  input  shader_to_sint_t       refl_data,
  output logic                  refl_stall,
  input  logic                  shad_valid,
  input  shader_to_sint_t       shad_data,
  output logic                  shad_stall,
  input  logic                  prim_valid,
  input  shader_to_sint_t       prim_data,
  output logic                  prim_stall,
  input  logic                  prim_retire,
  output logic                  sint_valid,
  output shader_to_sint_t       sint_data,
  input  logic                  sint_stall,
  output logic [PRIM_CNT_W-1:0] prim_inflight
);

  localparam logic [SINT_ARB_STARVE_W-1:0] STARVE_LIM = SINT_ARB_STARVE_W'(STARVE_MAX);
  localparam logic [PRIM_CNT_W-1:0]        PRIM_LIM   = PRIM_CNT_W'(MAX_PRIM);

  logic                         rst_q;
  arb_src_e                     rr_q;
  logic [SINT_ARB_STARVE_W-1:0] starve_q;
  logic [PRIM_CNT_W-1:0]        infl_q;
  logic [1:0]                   occ_q;

  logic            grant_open;
  logic            prim_elig;
  logic            grant_refl;
  logic            grant_shad;
  logic            grant_prim;
  logic            push;
  logic            pop;
  shader_to_sint_t push_data;

  // Priority select: starved primary, then round-robin secondaries, then primary.
  always_comb begin
    grant_open = !rst && !rst_q && (occ_q < 2'd2);
    prim_elig  = prim_valid && (infl_q < PRIM_LIM);
    grant_refl = 1'b0;
    grant_shad = 1'b0;
    grant_prim = 1'b0;
    if (grant_open) begin
      if (prim_elig && (starve_q == STARVE_LIM)) begin
        grant_prim = 1'b1;
      end else if (refl_valid && shad_valid) begin
        if (rr_q == SRC_SHAD) begin
          grant_shad = 1'b1;
        end else begin
          grant_refl = 1'b1;
        end
      end else if (refl_valid) begin
        grant_refl = 1'b1;
      end else if (shad_valid) begin
        grant_shad = 1'b1;
      end else if (prim_elig) begin
        grant_prim = 1'b1;
      end
    end
  end

  // Route the granted source's ray into the skid buffer.
  always_comb begin
    push_data = refl_data;
    if (grant_shad) begin
      push_data = shad_data;
    end else if (grant_prim) begin
      push_data = prim_data;
    end
  end

  assign push       = grant_refl || grant_shad || grant_prim;
  assign pop        = sint_valid && !sint_stall;
  assign refl_stall = refl_valid && !grant_refl;
  assign shad_stall = shad_valid && !grant_shad;
  assign prim_stall = prim_valid && !grant_prim;

  // Arbiter control state: reset shadow, rr pointer, starvation and credit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q    <= 1'b1;
      rr_q     <= SRC_REFL;
      starve_q <= '0;
      infl_q   <= '0;
    end else begin
      rst_q <= 1'b0;
      if (grant_refl) begin
        rr_q <= SRC_SHAD;
      end else if (grant_shad) begin
        rr_q <= SRC_REFL;
      end
      // A credit-blocked primary holds its count rather than climbing.
      if (grant_prim || !prim_valid) begin
        starve_q <= '0;
      end else if (prim_elig && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + SINT_ARB_STARVE_W'(1);
      end
      if (grant_prim && !prim_retire) begin
        infl_q <= infl_q + PRIM_CNT_W'(1);
      end else if (!grant_prim && prim_retire && (infl_q != '0)) begin
        infl_q <= infl_q - PRIM_CNT_W'(1);
      end
    end
  end

  sint_arb_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .occ_q     (occ_q),
    .head      (sint_data)
  );

  assign sint_valid    = (occ_q != 2'd0);
  assign prim_inflight = infl_q;

`ifndef SYNTH
  retire_underflow: assert property (@(posedge clk) disable iff (rst)
    !(prim_retire && (infl_q == '0)));
`endif

endmodule

// File: tb/tb_sint_arb.sv
// Bench for sint_arb: cycle model of grants with a scoreboard queue of
// expected sint rays, plus directed checks for each scenario.
module tb_sint_arb;
  import sint_arb_pkg::*;

  localparam int STARVE_MAX = 8;
  localparam int MAX_PRIM   = 4;

  logic            clk;
  logic            rst;
  logic            refl_valid, shad_valid, prim_valid;
  shader_to_sint_t refl_data, shad_data, prim_data;
  logic            refl_stall, shad_stall, prim_stall;
  logic            prim_retire;
  logic            sint_valid;
  shader_to_sint_t sint_data;
  logic            sint_stall;
  logic [PRIM_CNT_W-1:0] prim_inflight;

  sint_arb #(.STARVE_MAX(STARVE_MAX), .MAX_PRIM(MAX_PRIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .refl_valid    (refl_valid),
    .refl_data     (refl_data),
    .refl_stall    (refl_stall),
    .shad_valid    (shad_valid),
    .shad_data     (shad_data),
    .shad_stall    (shad_stall),
    .prim_valid    (prim_valid),
    .prim_data     (prim_data),
    .prim_stall    (prim_stall),
    .prim_retire   (prim_retire),
    .sint_valid    (sint_valid),
    .sint_data     (sint_data),
    .sint_stall    (sint_stall),
    .prim_inflight (prim_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic shader_to_sint_t mk_ray(input int src, input int n);
    shader_to_sint_t r;
    r.is_shadow = (src == 1);
    r.ray_id    = 16'(((src + 1) << 12) + n);
    r.payload   = {r.ray_id, ~r.ray_id};
    return r;
  endfunction

  // Drive controls
  bit d_rst, d_stall, d_retire;
  int n_refl, n_shad, n_prim;
  int refl_id, shad_id, prim_id;

  // Model state (0=refl, 1=shad, 2=prim, 3=none)
  shader_to_sint_t sb[$];
  int m_rr, m_starve, m_infl;
  bit m_rstq;

  // DUT-side observations
  logic [15:0] out_log[$];
  int dut_prim_acc, dut_refl_acc, dut_refl_stalls;
  logic [PRIM_CNT_W-1:0] last_infl;
  logic last_prim_stall, last_refl_stall, last_sint_valid;

  task automatic step();
    int  g;
    bit  ok, pe;
    @(negedge clk);
    rst         = d_rst;
    sint_stall  = d_stall;
    prim_retire = d_retire;
    refl_valid  = (n_refl > 0);
    shad_valid  = (n_shad > 0);
    prim_valid  = (n_prim > 0);
    refl_data   = mk_ray(0, refl_id);
    shad_data   = mk_ray(1, shad_id);
    prim_data   = mk_ray(2, prim_id);
    #1;
    ok = !d_rst && !m_rstq && (sb.size() < 2);
    pe = prim_valid && (m_infl < MAX_PRIM);
    g  = 3;
    if (ok) begin
      if (pe && m_starve == STARVE_MAX) g = 2;
      else if (refl_valid && shad_valid) g = m_rr;
      else if (refl_valid) g = 0;
      else if (shad_valid) g = 1;
      else if (pe) g = 2;
    end
    check_eq("refl_stall", refl_stall, refl_valid && (g != 0));
    check_eq("shad_stall", shad_stall, shad_valid && (g != 1));
    check_eq("prim_stall", prim_stall, prim_valid && (g != 2));
    check_eq("sint_valid", sint_valid, sb.size() != 0);
    check_eq("prim_inflight", prim_inflight, m_infl);
    if (sint_valid && sb.size() != 0) check_eq("sint_data", sint_data, sb[0]);
    if (prim_valid && !prim_stall) dut_prim_acc++;
    if (refl_valid && !refl_stall) dut_refl_acc++;
    if (refl_valid && refl_stall) dut_refl_stalls++;
    if (sint_valid && !sint_stall) out_log.push_back(sint_data.ray_id);
    last_infl       = prim_inflight;
    last_prim_stall = prim_stall;
    last_refl_stall = refl_stall;
    last_sint_valid = sint_valid;
    @(posedge clk);
    if (d_rst) begin
      sb.delete();
      m_rr = 0; m_starve = 0; m_infl = 0; m_rstq = 1'b1;
    end else begin
      m_rstq = 1'b0;
      if (sb.size() != 0 && !d_stall) void'(sb.pop_front());
      case (g)
        0: begin sb.push_back(refl_data); n_refl--; refl_id++; m_rr = 1; end
        1: begin sb.push_back(shad_data); n_shad--; shad_id++; m_rr = 0; end
        2: begin sb.push_back(prim_data); n_prim--; prim_id++; end
        default: ;
      endcase
      if (g == 2 || !prim_valid) m_starve = 0;
      else if (pe && m_starve < STARVE_MAX) m_starve++;
      if (g == 2 && !d_retire) m_infl++;
      else if (g != 2 && d_retire && m_infl > 0) m_infl--;
    end
    d_retire = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    run(2);
    d_rst = 1'b0;
    run(1);
  endtask

  initial begin
    int rb, sb0, pb, prim_wait;
    rst = 1'b1; sint_stall = 1'b0; prim_retire = 1'b0;
    refl_valid = 1'b0; shad_valid = 1'b0; prim_valid = 1'b0;
    refl_data = '0; shad_data = '0; prim_data = '0;
    d_rst = 1'b1; d_stall = 1'b0; d_retire = 1'b0;
    n_refl = 0; n_shad = 0; n_prim = 0;
    refl_id = 0; shad_id = 0; prim_id = 0;
    m_rr = 0; m_starve = 0; m_infl = 0; m_rstq = 1'b1;
    repeat (2) @(posedge clk);

    // Reset with all sources requesting: nothing accepted during rst and the release cycle.
    n_refl = 1; n_shad = 1; n_prim = 1;
    d_rst = 1'b1;
    run(2);
    d_rst = 1'b0;
    run(1);
    check_eq("rel_refl_stall", last_refl_stall, 1'b1);
    check_eq("rel_sint_valid", last_sint_valid, 1'b0);
    run(5);
    d_retire = 1'b1;
    run(3);

    // Single source streaming.
    out_log.delete(); dut_refl_stalls = 0; rb = refl_id;
    n_refl = 5;
    run(8);
    check_eq("single_cnt", out_log.size(), 5);
    for (int i = 0; i < 5; i++) check_eq("single_id", out_log[i], 16'(16'h1000 + rb + i));
    check_eq("single_stalls", dut_refl_stalls, 0);

    // Round-robin fairness from reset.
    do_reset();
    out_log.delete(); rb = refl_id; sb0 = shad_id;
    n_refl = 6; n_shad = 6;
    run(16);
    check_eq("rr_cnt", out_log.size(), 12);
    for (int i = 0; i < 12; i++)
      check_eq("rr_id", out_log[i],
               (i % 2 == 0) ? 16'(16'h1000 + rb + i / 2) : 16'(16'h2000 + sb0 + i / 2));

    // Starvation escape with all three sources valid.
    do_reset();
    run(1);
    out_log.delete(); dut_prim_acc = 0; prim_wait = 0;
    rb = refl_id; sb0 = shad_id; pb = prim_id;
    n_refl = 30; n_shad = 30; n_prim = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (dut_prim_acc > 0 && prim_wait == 0) prim_wait = k;
    end
    n_refl = 0; n_shad = 0;
    run(4);
    check_eq("starve_wait", prim_wait, 9);
    check_eq("starve_before", out_log[7], 16'(16'h2000 + sb0 + 3));
    check_eq("starve_prim", out_log[8], 16'(16'h3000 + pb));
    check_eq("starve_after", out_log[9], 16'(16'h1000 + rb + 4));
    d_retire = 1'b1;
    run(2);

    // Credit limit, single retire, then retire coinciding with a grant.
    do_reset();
    dut_prim_acc = 0;
    n_prim = 20;
    run(8);
    check_eq("cred_acc4", dut_prim_acc, 4);
    check_eq("cred_infl4", last_infl, 4);
    check_eq("cred_stall", last_prim_stall, 1'b1);
    d_retire = 1'b1;
    run(4);
    check_eq("cred_acc5", dut_prim_acc, 5);
    check_eq("cred_infl_back", last_infl, 4);
    d_retire = 1'b1;
    step();
    d_retire = 1'b1;
    step();
    step();
    check_eq("cred_same_cycle", last_infl, 3);
    check_eq("cred_acc7", dut_prim_acc, 7);
    n_prim = 0;

    // Backpressure: two buffered, then stall; release drains in order.
    do_reset();
    out_log.delete(); dut_refl_acc = 0; rb = refl_id;
    d_stall = 1'b1; n_refl = 6;
    run(10);
    check_eq("bp_acc", dut_refl_acc, 2);
    check_eq("bp_stall", last_refl_stall, 1'b1);
    check_eq("bp_valid", last_sint_valid, 1'b1);
    d_stall = 1'b0;
    run(10);
    check_eq("bp_cnt", out_log.size(), 6);
    for (int i = 0; i < 6; i++) check_eq("bp_id", out_log[i], 16'(16'h1000 + rb + i));

    // Reset in the middle of traffic with a full buffer and primaries in flight.
    do_reset();
    n_prim = 3;
    run(5);
    d_stall = 1'b1; n_refl = 3;
    run(4);
    check_eq("mid_pre_infl", last_infl, 3);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check_eq("mid_sint_valid", last_sint_valid, 1'b0);
    check_eq("mid_infl", last_infl, 0);
    check_eq("mid_refl_stall", last_refl_stall, 1'b1);
    d_stall = 1'b0; dut_refl_acc = 0;
    run(4);
    check_eq("mid_resume", dut_refl_acc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
